// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and helpers for the rx/tx pair.
//               UART_RX_PARITY_EN adds the PARITY receive state.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_t;

    // Clocks per oversampling tick, truncated.
    function automatic int uart_div(input int clk, input int baud, input int samp);
        return clk / (baud * samp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Oversampling tick generator; one o_tick every DIV clocks,
//               restartable with i_clear.
// Revision    : 1.0
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 325
) (
    input  logic clk_wz,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_wrap;

    always_ff @(posedge clk_wz) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with sticky ready/overrun and error pulses.
//               Define UART_RX_PARITY_EN to expect an even-parity bit.
// Revision    : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FR      = 50000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DBIT        = 8,
    parameter int RX_DIV_SAMP = 16
) (
    input  logic            clk_wz,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_rx_reset,
    output logic [DBIT-1:0] o_rx_data,
    output logic            o_rx_ready,
    output logic            o_rx_frame_err,
    output logic            o_rx_overrun,
    output logic            o_rx_parity_err
);

    localparam int DIV  = uart_div(CLK_FR, BAUD_RATE, RX_DIV_SAMP);
    localparam int HALF = RX_DIV_SAMP / 2;
    localparam int SCW  = $clog2(RX_DIV_SAMP);
    localparam int BCW  = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            r_rx_meta;
    logic            r_rx_s;
    rx_state_t       r_state;
    logic [SCW-1:0]  r_samp_cnt;
    logic [BCW-1:0]  r_bit_idx;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] r_data;
    logic            r_ready;
    logic            r_overrun;
    logic            r_frame_err;
    logic            w_tick;
    logic            w_start;
    logic            w_full_bit;
    logic            w_good_stop;
`ifdef UART_RX_PARITY_EN
    logic            r_parity_err;
    logic            r_par_bad;
`endif

    assign w_start    = (r_state == ST_IDLE) && !r_rx_s;
    assign w_full_bit = w_tick && (r_samp_cnt == SCW'(RX_DIV_SAMP - 1));
`ifdef UART_RX_PARITY_EN
    assign w_good_stop = r_rx_s && !r_par_bad;
`else
    assign w_good_stop = r_rx_s;
`endif

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk_wz  (clk_wz),
        .i_reset (i_reset),
        .i_clear (w_start),
        .o_tick  (w_tick)
    );

    // Two-flop synchronizer; idles high so reset looks like a quiet line.
    always_ff @(posedge clk_wz) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_wz) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_samp_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_ready      <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // A completing frame below overrides this consume.
            if (i_rx_reset) begin
                r_ready   <= 1'b0;
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_samp_cnt <= '0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_samp_cnt == SCW'(HALF - 1)) begin
                            r_samp_cnt <= '0;
                            r_bit_idx  <= '0;
`ifdef UART_RX_PARITY_EN
                            r_par_bad  <= 1'b0;
`endif
                            r_state    <= r_rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            r_samp_cnt <= r_samp_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_full_bit) begin
                        r_samp_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[DBIT-1:1]};
                        if (r_bit_idx == BCW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_full_bit) begin
                        r_samp_cnt <= '0;
                        if (r_rx_s != ^r_shift) begin
                            r_parity_err <= 1'b1;
                            r_par_bad    <= 1'b1;
                        end
                        r_state <= ST_STOP;
                    end else if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_full_bit) begin
                        r_samp_cnt <= '0;
                        r_state    <= ST_IDLE;
                        if (w_good_stop) begin
                            r_data  <= r_shift;
                            r_ready <= 1'b1;
                            if (r_ready && !i_rx_reset) begin
                                r_overrun <= 1'b1;
                            end
                        end else if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_samp_cnt <= r_samp_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rx_data      = r_data;
    assign o_rx_ready     = r_ready;
    assign o_rx_overrun   = r_overrun;
    assign o_rx_frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign o_rx_parity_err = r_parity_err;
`else
    assign o_rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

UART receiver for the debug link. Recovers 8N1 serial frames from the board RX pin and hands each byte to `Debug` over the `i_uart_rx_ready` / `i_uart_rx_data` / `o_uart_rx_reset` interface. In simulation benches, the testbench currently drives that interface directly. It is the receive counterpart of `tx`, sharing its clock, baud and bit-width parameters.

## Interface
- `CLK_FR`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `DBIT`, 8: data bits per frame.
- `RX_DIV_SAMP`, 16: oversampling ticks per bit; must be even, ≥ 4.
- `clk_wz`, in, 1: system clock from `clk_wiz_0`.
- `i_reset`, in, 1: reset i_reset, synchronous, active-high; clock clk_wz.
- `i_rx`, in, 1: asynchronous serial line, idle high.
- `i_rx_reset`, in, 1: consume strobe from `Debug` (`o_uart_rx_reset`); clears ready and overrun.
- `o_rx_data`, out, DBIT: last received byte, LSB = first data bit.
- `o_rx_ready`, out, 1: sticky byte-valid flag.
- `o_rx_frame_err`, out, 1: one-cycle pulse on a bad stop bit.
- `o_rx_overrun`, out, 1: sticky flag, set when a byte completes while `o_rx_ready` is already 1.
- `o_rx_parity_err`, out, 1: one-cycle pulse on a parity mismatch; tied 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- `i_rx` passes through a 2-FF synchronizer (reset value 1). All logic uses the synchronized line `rx_s`.
- Tick divisor: `DIV = CLK_FR / (BAUD_RATE*RX_DIV_SAMP)`, integer truncation (50 MHz/9600/16 gives 325). One `tick` pulse is produced every DIV clocks. The tick counter is cleared on start detection.
- FSM states are IDLE, START, DATA, (PARITY), STOP.
- IDLE: when `rx_s` is 0, clear the tick counter and go to START.
- START: at tick RX_DIV_SAMP/2 (mid-bit), resample. If 0, go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no flags.
- DATA: every RX_DIV_SAMP ticks, shift `rx_s` into the MSB of the shift register (right shift). After DBIT samples, go to PARITY if enabled, otherwise STOP.
- STOP: sample after RX_DIV_SAMP ticks.
  - If 1: load `o_rx_data` from the shift register and set `o_rx_ready`. If `o_rx_ready` was already 1, also set `o_rx_overrun`.
  - If 0: pulse `o_rx_frame_err`, leave `o_rx_data` and `o_rx_ready` unchanged, and go to IDLE.
- After a good stop bit, return to IDLE immediately; the next start edge may begin mid-stop-bit.
- `i_rx_reset` clears `o_rx_ready` and `o_rx_overrun` on the next edge. If it coincides with a byte completion, completion wins: ready=1 with the new data, and overrun is cleared.
- `o_rx_data` holds its value until the next good frame.

## Timing
- Reset values: `o_rx_data`=0, `o_rx_ready`=0, `o_rx_frame_err`=0, `o_rx_overrun`=0, `o_rx_parity_err`=0, FSM in IDLE, shift register 0.
- `i_reset` mid-frame aborts the frame immediately, with no flags raised.
- Synchronizer latency is 2 clocks from a pin edge to `rx_s`.
- Sample points, measured from the cycle `rx_s` first reads 0 (cycle 0):
  - mid-start at 8·DIV;
  - data bit k at (8+16·(k+1))·DIV;
  - stop bit at (8+16·(DBIT+1))·DIV, or +16·DIV more with parity.
- `o_rx_ready` (or `o_rx_frame_err`) rises on the clock after the stop sample. Defaults: 152·325 = 49400 clocks after cycle 0.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - one even-parity bit is expected between the last data bit and the stop bit;
  - on mismatch, pulse `o_rx_parity_err`, do not set ready, continue to STOP, then go to IDLE;
  - a frame with both a parity mismatch and a bad stop bit pulses both error flags.
- Not defined: the PARITY state is absent, frames are 8N1, and `o_rx_parity_err` is constant 0.

## Structure
- Shared package `uart_pkg`:
  - state enum `rx_state_t`;
  - constant function `uart_div(clk, baud, samp)`, also used by `tx`.
- Sub-module `uart_baud_gen`:
  - ports `clk_wz`, `i_reset`, `i_clear`, `o_tick`;
  - parameter DIV;
  - counter width `$clog2(DIV)`.
- The synchronizer, FSM, shift register and flags live in `uart_rx`.

## Test plan
Bench parameters: CLK_FR=6400, BAUD_RATE=100 (DIV=4, 64 clocks per bit) unless noted.
- **Send 0x64 ('d')**: `o_rx_ready` rises 152·4 = 608 clocks after start detection, `o_rx_data`=0x64; pulse `i_rx_reset` → ready=0 next clock.
- **Back-to-back 0x00, 0x23, 0x20, no consume**: final `o_rx_data`=0x20, `o_rx_ready`=1, `o_rx_overrun`=1; `i_rx_reset` clears both.
- **Glitch**: `i_rx` low for 8 clocks (< half bit) → FSM back in IDLE, no ready, no error.
- **Bad stop bit**: send 0xFF with stop bit = 0 → one-cycle `o_rx_frame_err`, `o_rx_ready` stays 0, `o_rx_data` unchanged.
- **Reset mid-frame**: assert `i_reset` during data bit 3 → all outputs 0 next clock; a following 0x63 frame is received correctly.
- **Parity** (`UART_RX_PARITY_EN`): 0x03 with parity bit 1 → `o_rx_parity_err` pulse, no ready; with parity bit 0 → ready, data=0x03.
